// File: rtl/if_stage_if.sv
// Fetch-stage bundle: imem req/gnt/rvalid channel, control redirect/stall, and the decode-facing output.
// master = fetch stage side, slave = memory/control/decode environment side.
interface if_stage_if;
  logic        if_imem_req_o;
  logic [31:0] if_imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ctrl_stall_i;
  logic        ctrl_flush_i;
  logic [31:0] ctrl_jump_addr_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  modport master (
    output if_imem_req_o, if_imem_addr_o, if_pc_o, if_inst_o, if_valid_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  ctrl_stall_i, ctrl_flush_i, ctrl_jump_addr_i
  );

  modport slave (
    input  if_imem_req_o, if_imem_addr_o, if_pc_o, if_inst_o, if_valid_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output ctrl_stall_i, ctrl_flush_i, ctrl_jump_addr_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with its generic show-ahead FIFO.

// Generic show-ahead FIFO with synchronous clear.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never pushes when full unless it also pops.
module if_stage_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  head_dat,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_vld)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !clr) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
endmodule

// Instruction fetch: owns the PC, issues imem word requests, buffers {pc, inst} pairs for decode.
// Latency: gnt in cycle N, rvalid in N+1, instruction presented in N+2; one per cycle sustained.
// Backpressure: stall holds the head; requests stop while in-flight plus buffered words reach DEPTH.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   jump_addr;
  logic [CW-1:0] os;
  logic [CW-1:0] discard;
  logic [CW-1:0] out_cnt;
  logic          out_empty;
  logic          pcq_empty;
  logic [31:0]   pcq_head;
  logic [63:0]   out_head;
  logic          flush;
  logic          pop;
  logic          grant;
  logic          resp_take;
  logic [CW:0]   used;

  assign flush     = bus.ctrl_flush_i;
  assign jump_addr = bus.ctrl_jump_addr_i & ~32'h3;
  assign pop       = !out_empty && !bus.ctrl_stall_i;

  // Credit covers live outstanding requests plus buffered words, net of this cycle's pop.
  assign used = {1'b0, os} + {1'b0, out_cnt} - {{CW{1'b0}}, pop};

  assign bus.if_imem_req_o  = !rst && !flush && (used < (CW + 1)'(DEPTH));
  assign bus.if_imem_addr_o = fetch_pc;
  assign grant              = bus.if_imem_req_o && bus.imem_gnt_i;
  assign resp_take          = bus.imem_rvalid_i && (discard == '0) && !pcq_empty && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
    end else if (flush) begin
      fetch_pc <= jump_addr;
      // Every pre-flush request becomes stale; an rvalid this cycle retires one of them either way.
      discard  <= discard + os - CW'(bus.imem_rvalid_i);
    end else begin
      if (grant) fetch_pc <= fetch_pc + 32'd4;
      if (bus.imem_rvalid_i && (discard != '0)) discard <= discard - CW'(1);
    end
  end

  // The outstanding count is exactly the PC queue occupancy.
  if_stage_fifo #(.W(32), .DEPTH(DEPTH), .CW(CW)) u_pc_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_vld (grant),
    .push_dat (fetch_pc),
    .pop_vld  (resp_take),
    .head_dat (pcq_head),
    .empty    (pcq_empty),
    .count    (os)
  );

  if_stage_fifo #(.W(64), .DEPTH(DEPTH), .CW(CW)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push_vld (resp_take),
    .push_dat ({pcq_head, bus.imem_rdata_i}),
    .pop_vld  (pop && !flush),
    .head_dat (out_head),
    .empty    (out_empty),
    .count    (out_cnt)
  );

  assign bus.if_valid_o = !out_empty;
  assign bus.if_pc_o    = out_empty ? 32'h0 : out_head[63:32];
  assign bus.if_inst_o  = out_empty ? NOP   : out_head[31:0];
endmodule
